// File: rtl/bcd_tens_comp_decoder.sv
// Serial 10's-complement BCD word decoder: buffers one word (LSD first) and
// re-emits it as sign + BCD magnitude, LSD first, using 9's complement + serial +1.
module bcd_tens_comp_decoder #(
   parameter int DIGITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_digit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_digit,
   output logic       out_sign,
   output logic       out_last,
   output logic       out_err
);

   // state   | meaning
   // COLLECT | accepting input digits into the buffer
   // EMIT    | presenting sign + magnitude digits downstream
   typedef enum logic [0:0] {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   state_t        state, state_next;
   logic [3:0]    buffer [DIGITS];
   logic [IW-1:0] idx;
   logic          carry;
   logic          neg;
   logic          err;

   logic          in_fire;
   logic          out_fire;
   logic          idx_last;
   logic          digit_bad;
   logic [3:0]    digit_store;
   logic [3:0]    cur;
   logic [3:0]    t;
   logic          t_wrap;
   logic [3:0]    mag;
   logic          carry_next;

   assign in_ready    = (state == COLLECT);
   assign out_valid   = (state == EMIT);
   assign in_fire     = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign idx_last    = (idx == IDX_LAST);
   assign digit_bad   = (in_digit > 4'd9);
   assign digit_store = digit_bad ? 4'd0 : in_digit;

   // t spans 0..10; 10 wraps to 0 and propagates the +1 into the next digit
   assign cur        = buffer[idx];
   assign t          = (4'd9 - cur) + {3'b000, carry};
   assign t_wrap     = (t == 4'd10);
   assign mag        = neg ? (t_wrap ? 4'd0 : t) : cur;
   assign carry_next = neg && t_wrap;

   // Outputs are forced to zero outside EMIT so the idle bus is quiet
   assign out_digit = out_valid ? mag : 4'd0;
   assign out_sign  = out_valid && neg;
   assign out_last  = out_valid && idx_last;
   assign out_err   = out_valid && err;

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (in_fire && idx_last)  state_next = EMIT;
         EMIT:    if (out_fire && idx_last) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         carry <= 1'b0;
         neg   <= 1'b0;
         err   <= 1'b0;
         for (int i = 0; i < DIGITS; i++) buffer[i] <= 4'd0;
      end else if (in_fire) begin
         buffer[idx] <= digit_store;
         err         <= ((idx == '0) ? 1'b0 : err) | digit_bad;
         if (idx_last) begin
            // an invalid MSD is stored as 0 and therefore reads as positive
            neg   <= (digit_store >= 4'd5);
            carry <= (digit_store >= 4'd5);
            idx   <= '0;
         end else begin
            idx <= idx + IW'(1);
         end
      end else if (out_fire) begin
         carry <= carry_next;
         idx   <= idx_last ? '0 : idx + IW'(1);
      end
   end

endmodule

// File: doc/bcd_tens_comp_decoder.md
# bcd_tens_comp_decoder

Serial decoder that accepts DIGITS-digit 10's-complement BCD words, one digit per handshake, least-significant digit first, and re-emits each word as sign plus BCD magnitude on a second serial handshake, LSD first. It is the receive-side counterpart of the team's 9's-complement digit generator. It recovers signed decimal values for display and compare logic: 9's complement of each digit, then a serial +1 ripple. It buffers one full word, because the sign is known only from the most-significant digit.

## Interface
- DIGITS, 4, digits per word; legal range 2..8.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_digit is offered.
- in_ready  output  1  block accepts a digit; equal to (state == COLLECT).
- in_digit  input  4  BCD digit, encoded as a 10's-complement word.
- out_valid  output  1  out_digit, out_sign, out_last and out_err are valid; equal to (state == EMIT).
- out_ready  input  1  downstream accepts the current output digit.
- out_digit  output  4  magnitude digit, LSD first.
- out_sign  output  1  1 = negative; constant for the whole word.
- out_last  output  1  marks the most-significant digit (index DIGITS-1).
- out_err  output  1  the word contained at least one digit > 9; constant for the whole word.

## Operation
- Storage:
  - digit buffer: DIGITS x 4 bits.
  - index counter: width clog2(DIGITS).
  - carry flag.
  - neg flag.
  - err flag.
  - 1-bit state: COLLECT or EMIT.
- Input acceptance: a digit is accepted when in_valid && in_ready.
- COLLECT:
  - Each accepted digit is written to buffer[idx], and idx increments.
  - A digit > 9 is stored as 0 and sets err.
  - err is cleared at the first accepted digit of each word.
  - When digit idx == DIGITS-1 is accepted:
    - neg <= (stored MSD >= 5); an invalid MSD (stored as 0) gives neg = 0.
    - carry <= neg.
    - idx <= 0.
    - state <= EMIT.
- EMIT:
  - When neg = 0: out_digit = buffer[idx].
  - When neg = 1: t = (9 - buffer[idx]) + carry.
    - If t == 10: out_digit = 0 and the next carry is 1.
    - Otherwise: out_digit = t and the next carry is 0.
- Output advance:
  - On out_valid && out_ready, carry and idx update.
  - out_last = (idx == DIGITS-1).
  - After the out_last digit is accepted: idx <= 0, state <= COLLECT.
- Arithmetic width:
  - All digit arithmetic is 4-bit.
  - The intermediate t must hold 0..10.
  - No carry leaves the MSD. For neg words the MSD is >= 5, so the final t is <= 5.
- Output stability: out_digit, out_sign, out_last and out_err are functions of the registered state only. They hold stable while out_valid && !out_ready.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - state = COLLECT, idx = 0, carry = 0, neg = 0, err = 0.
  - in_ready = 1, out_valid = 0.
  - out_digit = 0, out_sign = 0, out_last = 0, out_err = 0.
- rst during COLLECT or EMIT aborts the word. The partial word is discarded and never emitted.
- Latency: out_valid rises in the cycle after the MSD handshake. First digit out is 1 cycle after the last digit in.
- Word occupancy:
  - Minimum: 2*DIGITS cycles per word with continuous valid/ready.
  - in_ready = 1 again in the cycle after the out_last handshake.
- No overlap: input and output phases never overlap.
  - in_ready = 0 throughout EMIT.
  - out_valid = 0 throughout COLLECT.
- Handshake rules:
  - in_valid may drop between digits; idx holds.
  - out_ready may drop at any time; the output holds without loss.
  - Back-to-back words are accepted without a gap cycle beyond the first in_ready cycle.

## Test plan
- Reset check:
  - Stimulus: hold rst for 2 cycles.
  - Required response: in_ready = 1 and out_valid = 0, with all outputs 0.
- Negative word, continuous flow:
  - Stimulus: DIGITS = 4, input 7,7,8,9 (the word 9877), out_ready = 1.
  - Required response: output 3,2,1,0, out_sign = 1 on every digit, out_last only on the 4th digit (-123).
- Carry ripple through zeros:
  - Stimulus: input 0,0,0,9 (the word 9000).
  - Required response: output 0,0,0,1, out_sign = 1 (-1000).
- Sign boundaries:
  - Stimulus: input 0,0,0,5 (the word 5000).
  - Required response: output 0,0,0,5, out_sign = 1.
  - Stimulus: input 9,9,9,4 (the word 4999).
  - Required response: output 9,9,9,4, out_sign = 0.
  - Stimulus: input 0,0,0,0.
  - Required response: output 0,0,0,0, out_sign = 0.
- Backpressure and gaps:
  - Stimulus: in_valid toggling; out_ready low for 3 cycles on digit 2.
  - Required response:
    - out_digit, out_sign and out_last hold stable during the stall.
    - No digit is duplicated or dropped.
    - in_ready = 0 throughout EMIT.
- Invalid digit and reset mid-word:
  - Stimulus: input 3,12,1,0.
  - Required response: output 3,0,1,0, out_err = 1 on all 4 digits, and out_err = 0 on the next word.
  - Stimulus: rst asserted after 2 accepted digits, then a fresh word 1,2,3,4.
  - Required response: output 1,2,3,4 only, out_sign = 0.
